// File: rtl/not_not_answer_judge.sv
// not_not_answer_judge: latches the prompt pattern, judges the player's SW/KEY answer,
// keeps score and lives. Define NOT_NOT_TIMEOUT_EN to build the per-round answer timer.
module not_not_answer_judge #(
  parameter int unsigned ROUND_CYCLES  = 150000000,
  parameter int unsigned RESULT_CYCLES = 25000000,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned SCORE_W       = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               round_start,
  input  logic [3:0]         expected,
  input  logic [3:0]         answer,
  input  logic               submit_n,
  output logic               ready,
  output logic               next_round,
  output logic               verdict_correct,
  output logic               verdict_wrong,
  output logic               verdict_timeout,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives,
  output logic               game_over
);

  typedef enum logic [1:0] {IDLE, ARMED, RESULT, OVER} state_t;

  // One down-counter serves as the answer timer in ARMED and the verdict hold in RESULT.
  localparam int unsigned CNT_MAX = (ROUND_CYCLES > RESULT_CYCLES) ? ROUND_CYCLES : RESULT_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RESULT_CYCLES - 1);
`ifdef NOT_NOT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] ROUND_LOAD = CNT_W'(ROUND_CYCLES - 1);
`endif

  logic [3:0]         ans_meta, ans_sync;
  logic               sub_meta, sub_sync, sub_prev;
  logic               submit;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         exp_q, exp_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         lives_q, lives_d;
  logic               correct_q, correct_d;
  logic               wrong_q, wrong_d;
  logic               next_q, next_d;
`ifdef NOT_NOT_TIMEOUT_EN
  logic               timeout_q, timeout_d;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ans_meta <= '0;
      ans_sync <= '0;
      sub_meta <= 1'b1;
      sub_sync <= 1'b1;
      sub_prev <= 1'b1;
    end else begin
      ans_meta <= answer;
      ans_sync <= ans_meta;
      sub_meta <= submit_n;
      sub_sync <= sub_meta;
      sub_prev <= sub_sync;
    end
  end

  // Falling edge of the synchronized key: one pulse per press regardless of hold time.
  assign submit = sub_prev & ~sub_sync;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    score_d   = score_q;
    lives_d   = lives_q;
    correct_d = correct_q;
    wrong_d   = wrong_q;
    next_d    = 1'b0;
`ifdef NOT_NOT_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (round_start) begin
          exp_d   = expected;
          state_d = ARMED;
`ifdef NOT_NOT_TIMEOUT_EN
          cnt_d   = ROUND_LOAD;
`endif
        end
      end
      ARMED: begin
        if (submit) begin
          cnt_d   = HOLD_LOAD;
          state_d = RESULT;
          if (ans_sync == exp_q) begin
            correct_d = 1'b1;
            if (score_q != '1) score_d = score_q + SCORE_W'(1);
          end else begin
            wrong_d = 1'b1;
            if (lives_q != '0) lives_d = lives_q - 4'd1;
          end
        end
`ifdef NOT_NOT_TIMEOUT_EN
        else if (cnt_q == '0) begin
          timeout_d = 1'b1;
          if (lives_q != '0) lives_d = lives_q - 4'd1;
          cnt_d   = HOLD_LOAD;
          state_d = RESULT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`endif
      end
      RESULT: begin
        if (cnt_q == '0) begin
          correct_d = 1'b0;
          wrong_d   = 1'b0;
`ifdef NOT_NOT_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          if (lives_q == '0) begin
            state_d = OVER;
          end else begin
            next_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      OVER: begin
        state_d = OVER;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      exp_q     <= '0;
      score_q   <= '0;
      lives_q   <= 4'(LIVES);
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      next_q    <= 1'b0;
`ifdef NOT_NOT_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      next_q    <= next_d;
`ifdef NOT_NOT_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  assign ready           = (state_q == IDLE);
  assign game_over       = (state_q == OVER);
  assign next_round      = next_q;
  assign verdict_correct = correct_q;
  assign verdict_wrong   = wrong_q;
`ifdef NOT_NOT_TIMEOUT_EN
  assign verdict_timeout = timeout_q;
`else
  assign verdict_timeout = 1'b0;
`endif
  assign score           = score_q;
  assign lives           = lives_q;

endmodule

// File: tb/tb_not_not_answer_judge.sv
// Bench for not_not_answer_judge: timestamp-based reference model checked every cycle,
// plus directed rounds with hand-computed expectations.
module tb_not_not_answer_judge;

  localparam int ROUND   = 20;
  localparam int RESULT  = 4;
  localparam int LIV     = 2;
  localparam int SW      = 8;
  localparam int SMAX    = (1 << SW) - 1;
  localparam int HN      = 4096;

  logic          clock, reset, round_start, submit_n;
  logic [3:0]    expected, answer;
  logic          ready, next_round, verdict_correct, verdict_wrong, verdict_timeout, game_over;
  logic [SW-1:0] score;
  logic [3:0]    lives;

  int n_checks = 0;
  int n_pass   = 0;

  not_not_answer_judge #(
    .ROUND_CYCLES (ROUND),
    .RESULT_CYCLES(RESULT),
    .LIVES        (LIV),
    .SCORE_W      (SW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .round_start    (round_start),
    .expected       (expected),
    .answer         (answer),
    .submit_n       (submit_n),
    .ready          (ready),
    .next_round     (next_round),
    .verdict_correct(verdict_correct),
    .verdict_wrong  (verdict_wrong),
    .verdict_timeout(verdict_timeout),
    .score          (score),
    .lives          (lives),
    .game_over      (game_over)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: edge-indexed input history, absolute deadlines per round.
  typedef enum int {P_IDLE, P_ARMED, P_RESULT, P_OVER} phase_t;
  phase_t     m_phase;
  int         m_edge, m_deadline, m_end, m_score, m_lives;
  logic [3:0] m_exp;
  logic       m_c, m_w, m_t, m_nr;
  logic       sub_hist [HN];
  logic [3:0] ans_hist [HN];

  function automatic logic sub_at(input int i);
    if (i < 0) return 1'b1;
    return sub_hist[i % HN];
  endfunction

  function automatic logic [3:0] ans_at(input int i);
    if (i < 0) return 4'd0;
    return ans_hist[i % HN];
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_phase <= P_IDLE; m_edge <= 0; m_score <= 0; m_lives <= LIV;
      m_c <= 1'b0; m_w <= 1'b0; m_t <= 1'b0; m_nr <= 1'b0;
      m_exp <= 4'd0; m_deadline <= 0; m_end <= 0;
    end else begin
      sub_hist[m_edge % HN] <= submit_n;
      ans_hist[m_edge % HN] <= answer;
      m_edge <= m_edge + 1;
      m_nr   <= 1'b0;
      case (m_phase)
        P_IDLE:
          if (round_start) begin
            m_exp      <= expected;
            m_deadline <= m_edge + ROUND;
            m_phase    <= P_ARMED;
          end
        P_ARMED:
          if (sub_at(m_edge - 3) && !sub_at(m_edge - 2)) begin
            m_end   <= m_edge + RESULT;
            m_phase <= P_RESULT;
            if (ans_at(m_edge - 2) == m_exp) begin
              m_c     <= 1'b1;
              m_score <= (m_score == SMAX) ? m_score : m_score + 1;
            end else begin
              m_w     <= 1'b1;
              m_lives <= (m_lives > 0) ? m_lives - 1 : 0;
            end
          end
`ifdef NOT_NOT_TIMEOUT_EN
          else if (m_edge == m_deadline) begin
            m_t     <= 1'b1;
            m_lives <= (m_lives > 0) ? m_lives - 1 : 0;
            m_end   <= m_edge + RESULT;
            m_phase <= P_RESULT;
          end
`endif
        P_RESULT:
          if (m_edge == m_end) begin
            m_c <= 1'b0; m_w <= 1'b0; m_t <= 1'b0;
            if (m_lives == 0) m_phase <= P_OVER;
            else begin
              m_nr    <= 1'b1;
              m_phase <= P_IDLE;
            end
          end
        default: ;
      endcase
    end
  end

  always @(posedge clock) begin
    #1;
    chk("cyc_ready",     ready,           m_phase == P_IDLE);
    chk("cyc_next",      next_round,      m_nr);
    chk("cyc_correct",   verdict_correct, m_c);
    chk("cyc_wrong",     verdict_wrong,   m_w);
    chk("cyc_timeout",   verdict_timeout, m_t);
    chk("cyc_score",     score,           m_score);
    chk("cyc_lives",     lives,           m_lives);
    chk("cyc_game_over", game_over,       m_phase == P_OVER);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic start_round(input logic [3:0] pat);
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    chk("ready_wait", ready, 1);
    expected    = pat;
    round_start = 1'b1;
    tick(1);
    round_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; round_start = 1'b0; expected = 4'd0; answer = 4'd0; submit_n = 1'b1;
    tick(3);
    chk("rst_ready", ready, 1);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 2);
    chk("rst_over",  game_over, 0);
    chk("rst_next",  next_round, 0);
    reset = 1'b1;
    tick(2);

    // Correct answer: verdict three edges after the key falls, held four cycles.
    start_round(4'b0101);
    tick(2);
    answer = 4'b0101; submit_n = 1'b0;
    tick(2); chk("b_latency_early", verdict_correct, 0);
    tick(1); chk("b_correct", verdict_correct, 1);
    chk("b_score", score, 1); chk("b_lives", lives, 2);
    submit_n = 1'b1;
    tick(3); chk("b_hold_last", verdict_correct, 1);
    tick(1); chk("b_clear", verdict_correct, 0);
    chk("b_next", next_round, 1); chk("b_ready", ready, 1);
    tick(1); chk("b_next_once", next_round, 0);

    // Wrong answer.
    start_round(4'b1110);
    tick(2);
    answer = 4'b0001; submit_n = 1'b0;
    tick(3);
    chk("c_wrong", verdict_wrong, 1); chk("c_lives", lives, 1); chk("c_score", score, 1);
    submit_n = 1'b1;
    tick(4); chk("c_clear", verdict_wrong, 0); chk("c_next", next_round, 1);

    // Key held 50 cycles, round_start during RESULT ignored.
    start_round(4'b0011);
    tick(2);
    answer = 4'b0011; submit_n = 1'b0;
    tick(3); chk("d_correct", verdict_correct, 1); chk("d_score", score, 2);
    round_start = 1'b1; expected = 4'b1111;
    tick(1); round_start = 1'b0;
    chk("d_ready_result", ready, 0);
    tick(46);
    submit_n = 1'b1;
    tick(5);
    chk("d_one_judge", score, 2); chk("d_lives", lives, 1); chk("d_idle", ready, 1);

`ifdef NOT_NOT_TIMEOUT_EN
    reset = 1'b0; tick(1); reset = 1'b1; tick(1);
    start_round(4'b1000);
    tick(19); chk("e_timeout_early", verdict_timeout, 0);
    tick(1);  chk("e_timeout", verdict_timeout, 1); chk("e_lives", lives, 1);
    tick(4);  chk("e_clear", verdict_timeout, 0); chk("e_next", next_round, 1);
    start_round(4'b0100);
    tick(20); chk("e_timeout2", verdict_timeout, 1); chk("e_lives0", lives, 0);
    tick(4);  chk("e_over", game_over, 1); chk("e_no_next", next_round, 0);
    round_start = 1'b1; answer = 4'b0100; submit_n = 1'b0;
    tick(1); round_start = 1'b0;
    tick(5); submit_n = 1'b1; tick(2);
    chk("e_over_hold", game_over, 1); chk("e_over_score", score, 0);
    chk("e_over_lives", lives, 0); chk("e_over_ready", ready, 0);

    // Submit judged on the same edge the timer would expire.
    reset = 1'b0; tick(1); reset = 1'b1; tick(1);
    start_round(4'b1001);
    tick(17);
    answer = 4'b1001; submit_n = 1'b0;
    tick(3);
    chk("f_correct", verdict_correct, 1); chk("f_no_timeout", verdict_timeout, 0);
    chk("f_score", score, 1);
    submit_n = 1'b1;
    tick(6);
`else
    start_round(4'b0110);
    tick(1000);
    chk("n_no_timeout", verdict_timeout, 0); chk("n_armed", ready, 0);
    chk("n_no_correct", verdict_correct, 0); chk("n_no_wrong", verdict_wrong, 0);
    answer = 4'b0110; submit_n = 1'b0;
    tick(3);
    chk("n_correct", verdict_correct, 1); chk("n_score", score, 3);
    submit_n = 1'b1;
    tick(6);
`endif

    // Asynchronous reset mid-round.
    start_round(4'b0010);
    tick(5);
    chk("g_armed", ready, 0);
    reset = 1'b0;
    #1;
    chk("g_ready", ready, 1); chk("g_score", score, 0); chk("g_lives", lives, 2);
    chk("g_over", game_over, 0);
    tick(2);
    reset = 1'b1;
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
